// File: rtl/gpio_input_conditioner.sv
// GPIO input front end: per-bit synchroniser, debouncer, edge detector and sticky
// edge-event latches that are ORed into a single interrupt line.
module gpio_input_conditioner #(
   parameter int WIDTH           = 32,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pad_input,
   input  logic [WIDTH-1:0] debounce_enable,
   input  logic [WIDTH-1:0] rise_enable,
   input  logic [WIDTH-1:0] fall_enable,
   input  logic [WIDTH-1:0] irq_enable,
   input  logic [WIDTH-1:0] event_clear,
   output logic [WIDTH-1:0] gpio_input_conditioned,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] event_pending,
   output logic             irq
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r [WIDTH];
   logic [CNT_W-1:0]       cnt_r [WIDTH];
   logic [CNT_W-1:0]       cnt_nxt_s [WIDTH];
   logic [WIDTH-1:0]       synced_s;
   logic [WIDTH-1:0]       stable_r;
   logic [WIDTH-1:0]       stable_nxt_s;
   logic [WIDTH-1:0]       stable_q_r;
   logic [WIDTH-1:0]       pending_r;
   logic [WIDTH-1:0]       pending_nxt_s;
   logic [WIDTH-1:0]       set_s;

   // Tap the last synchroniser stage of each bit
   always_comb begin
      synced_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         synced_s[i] = sync_r[i][SYNC_STAGES-1];
      end
   end

   // Debounce next state: a mismatch must survive DEBOUNCE_CYCLES edges to be accepted
   always_comb begin
      stable_nxt_s = stable_r;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt_s[i] = {CNT_W{1'b0}};
         if (debounce_enable[i] == 1'b0) begin
            stable_nxt_s[i] = synced_s[i];
         end else if (synced_s[i] == stable_r[i]) begin
            cnt_nxt_s[i] = {CNT_W{1'b0}};
         end else if (cnt_r[i] == CNT_LAST) begin
            stable_nxt_s[i] = synced_s[i];
         end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
         end
      end
   end

   // Pending next state: a new edge event wins over a simultaneous clear
   always_comb begin
      set_s         = (rise_pulse & rise_enable) | (fall_pulse & fall_enable);
      pending_nxt_s = set_s | (pending_r & ~event_clear);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (reset_n == 1'b0) begin
         for (int i = 0; i < WIDTH; i++) begin
            sync_r[i] <= {SYNC_STAGES{1'b0}};
            cnt_r[i]  <= {CNT_W{1'b0}};
         end
         stable_r   <= {WIDTH{1'b0}};
         stable_q_r <= {WIDTH{1'b0}};
         pending_r  <= {WIDTH{1'b0}};
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], pad_input[i]};
            cnt_r[i]  <= cnt_nxt_s[i];
         end
         stable_r   <= stable_nxt_s;
         stable_q_r <= stable_r;
         pending_r  <= pending_nxt_s;
      end
   end

   // Outputs derive from registered state only; irq reacts to irq_enable in the same cycle
   always_comb begin
      gpio_input_conditioned = stable_r;
      rise_pulse             = stable_r & ~stable_q_r;
      fall_pulse             = ~stable_r & stable_q_r;
      event_pending          = pending_r;
      irq                    = |(pending_r & irq_enable);
   end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner: expected values are queued when
// stimulus is applied and popped when the corresponding output cycle is reached.
module tb_gpio_input_conditioner;

   logic        clock;
   logic        reset_n;
   logic [31:0] pad_input;
   logic [31:0] debounce_enable;
   logic [31:0] rise_enable;
   logic [31:0] fall_enable;
   logic [31:0] irq_enable;
   logic [31:0] event_clear;
   logic [31:0] gpio_input_conditioned;
   logic [31:0] rise_pulse;
   logic [31:0] fall_pulse;
   logic [31:0] event_pending;
   logic        irq;

   logic [31:0] sb [$];
   logic [31:0] e;
   int          vectors;
   int          miscompares;

   gpio_input_conditioner #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
      .clock                  (clock),
      .reset_n                (reset_n),
      .pad_input              (pad_input),
      .debounce_enable        (debounce_enable),
      .rise_enable            (rise_enable),
      .fall_enable            (fall_enable),
      .irq_enable             (irq_enable),
      .event_clear            (event_clear),
      .gpio_input_conditioned (gpio_input_conditioned),
      .rise_pulse             (rise_pulse),
      .fall_pulse             (fall_pulse),
      .event_pending          (event_pending),
      .irq                    (irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance n rising edges; return at the following falling edge for sampling/driving
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0; pad_input = 32'h0; debounce_enable = 32'hFFFF_FFFF;
      rise_enable = 32'h0; fall_enable = 32'h0; irq_enable = 32'h0; event_clear = 32'h0;
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pad_input = 32'hFFFF_FFFF; debounce_enable = 32'hFFFF_FFFF;
      rise_enable = 32'hFFFF_FFFF; fall_enable = 32'hFFFF_FFFF; irq_enable = 32'h0; event_clear = 32'h0;
      sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
      tick(10);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL reset_cond got %h want %h", gpio_input_conditioned, e); end
      e = sb.pop_front(); vectors++;
      if ((rise_pulse | fall_pulse) !== e) begin miscompares++; $display("FAIL reset_pulses got %h want %h", rise_pulse | fall_pulse, e); end
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL reset_pending got %h want %h", event_pending, e); end
      e = sb.pop_front(); vectors++;
      if ({31'h0, irq} !== e) begin miscompares++; $display("FAIL reset_irq got %h want %h", irq, e); end
      reset_n = 1'b1;
      sb.push_back(32'h0);
      tick(17);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL rel_cond_e17 got %h want %h", gpio_input_conditioned, e); end
      sb.push_back(32'hFFFF_FFFF); sb.push_back(32'hFFFF_FFFF);
      tick(1);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL rel_cond_e18 got %h want %h", gpio_input_conditioned, e); end
      e = sb.pop_front(); vectors++;
      if (rise_pulse !== e) begin miscompares++; $display("FAIL rel_rise got %h want %h", rise_pulse, e); end
      sb.push_back(32'h0); sb.push_back(32'hFFFF_FFFF);
      tick(1);
      e = sb.pop_front(); vectors++;
      if (rise_pulse !== e) begin miscompares++; $display("FAIL rel_rise_end got %h want %h", rise_pulse, e); end
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL rel_pending got %h want %h", event_pending, e); end
      irq_enable = 32'h8000_0000;
      sb.push_back(32'h1);
      #1;
      e = sb.pop_front(); vectors++;
      if ({31'h0, irq} !== e) begin miscompares++; $display("FAIL rel_irq got %h want %h", irq, e); end
      @(negedge clock);
      event_clear = 32'hFFFF_FFFF;
      sb.push_back(32'h0);
      tick(1);
      event_clear = 32'h0;
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL rel_clear got %h want %h", event_pending, e); end
   endtask

   task automatic test_debounce();
      logic rise_seen;
      logic fall_seen;
      logic cond_seen;
      do_reset();
      pad_input = 32'h1;
      sb.push_back(32'h0);
      tick(17);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL deb_e17 got %h want %h", gpio_input_conditioned, e); end
      sb.push_back(32'h1); sb.push_back(32'h1);
      tick(1);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL deb_e18 got %h want %h", gpio_input_conditioned, e); end
      e = sb.pop_front(); vectors++;
      if (rise_pulse !== e) begin miscompares++; $display("FAIL deb_rise got %h want %h", rise_pulse, e); end
      pad_input = 32'h0;
      sb.push_back(32'h1); sb.push_back(32'h0); sb.push_back(32'h1);
      tick(17);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL deb_fall_e17 got %h want %h", gpio_input_conditioned, e); end
      tick(1);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL deb_fall_e18 got %h want %h", gpio_input_conditioned, e); end
      e = sb.pop_front(); vectors++;
      if (fall_pulse !== e) begin miscompares++; $display("FAIL deb_fall_pulse got %h want %h", fall_pulse, e); end
      tick(3);
      // 15-cycle glitch must be rejected
      pad_input = 32'h1;
      sb.push_back(32'h0); sb.push_back(32'h0);
      rise_seen = 1'b0; cond_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == 15) pad_input = 32'h0;
         tick(1);
         rise_seen = rise_seen | rise_pulse[0];
         cond_seen = cond_seen | gpio_input_conditioned[0];
      end
      e = sb.pop_front(); vectors++;
      if ({31'h0, rise_seen} !== e) begin miscompares++; $display("FAIL glitch15_rise got %h want %h", rise_seen, e); end
      e = sb.pop_front(); vectors++;
      if ({31'h0, cond_seen} !== e) begin miscompares++; $display("FAIL glitch15_cond got %h want %h", cond_seen, e); end
      // 16-cycle pulse is just long enough to be accepted, then released
      pad_input = 32'h1;
      sb.push_back(32'h1); sb.push_back(32'h1);
      rise_seen = 1'b0; fall_seen = 1'b0;
      for (int i = 0; i < 45; i++) begin
         if (i == 16) pad_input = 32'h0;
         tick(1);
         rise_seen = rise_seen | rise_pulse[0];
         fall_seen = fall_seen | fall_pulse[0];
      end
      e = sb.pop_front(); vectors++;
      if ({31'h0, rise_seen} !== e) begin miscompares++; $display("FAIL pulse16_rise got %h want %h", rise_seen, e); end
      e = sb.pop_front(); vectors++;
      if ({31'h0, fall_seen} !== e) begin miscompares++; $display("FAIL pulse16_fall got %h want %h", fall_seen, e); end
   endtask

   task automatic test_bypass();
      do_reset();
      debounce_enable = 32'hFFFF_FFF7;
      pad_input = 32'h8;
      sb.push_back(32'h0); sb.push_back(32'h8); sb.push_back(32'h8);
      tick(2);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL byp_e2 got %h want %h", gpio_input_conditioned, e); end
      tick(1);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL byp_e3 got %h want %h", gpio_input_conditioned, e); end
      e = sb.pop_front(); vectors++;
      if (rise_pulse !== e) begin miscompares++; $display("FAIL byp_rise got %h want %h", rise_pulse, e); end
      pad_input = 32'h0;
      sb.push_back(32'h8); sb.push_back(32'h0); sb.push_back(32'h8);
      tick(2);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL byp_fall_e2 got %h want %h", gpio_input_conditioned, e); end
      tick(1);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL byp_fall_e3 got %h want %h", gpio_input_conditioned, e); end
      e = sb.pop_front(); vectors++;
      if (fall_pulse !== e) begin miscompares++; $display("FAIL byp_fall got %h want %h", fall_pulse, e); end
      // debounce aborted on bit0 once its count has reached 7
      debounce_enable = 32'hFFFF_FFFF;
      pad_input = 32'h1;
      sb.push_back(32'h0); sb.push_back(32'h1);
      tick(9);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL abort_cnt7 got %h want %h", gpio_input_conditioned, e); end
      debounce_enable = 32'hFFFF_FFFE;
      tick(1);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL abort_pass got %h want %h", gpio_input_conditioned, e); end
   endtask

   task automatic test_events();
      do_reset();
      rise_enable = 32'h1; fall_enable = 32'h0; irq_enable = 32'h1;
      pad_input = 32'h1;
      sb.push_back(32'h1); sb.push_back(32'h0); sb.push_back(32'h1); sb.push_back(32'h1);
      tick(18);
      e = sb.pop_front(); vectors++;
      if (rise_pulse !== e) begin miscompares++; $display("FAIL ev_rise got %h want %h", rise_pulse, e); end
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL ev_pend_early got %h want %h", event_pending, e); end
      tick(1);
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL ev_pend got %h want %h", event_pending, e); end
      e = sb.pop_front(); vectors++;
      if ({31'h0, irq} !== e) begin miscompares++; $display("FAIL ev_irq got %h want %h", irq, e); end
      irq_enable = 32'h0;
      sb.push_back(32'h0); sb.push_back(32'h1);
      #1;
      e = sb.pop_front(); vectors++;
      if ({31'h0, irq} !== e) begin miscompares++; $display("FAIL ev_irq_mask got %h want %h", irq, e); end
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL ev_mask_pend got %h want %h", event_pending, e); end
      irq_enable = 32'h1;
      @(negedge clock);
      event_clear = 32'h1;
      sb.push_back(32'h0); sb.push_back(32'h0);
      tick(1);
      event_clear = 32'h0;
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL ev_clear got %h want %h", event_pending, e); end
      e = sb.pop_front(); vectors++;
      if ({31'h0, irq} !== e) begin miscompares++; $display("FAIL ev_clear_irq got %h want %h", irq, e); end
      pad_input = 32'h0;
      sb.push_back(32'h1); sb.push_back(32'h0); sb.push_back(32'h0);
      tick(17);
      tick(1);
      e = sb.pop_front(); vectors++;
      if (fall_pulse !== e) begin miscompares++; $display("FAIL ev_fall got %h want %h", fall_pulse, e); end
      tick(1);
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL ev_fall_nopend got %h want %h", event_pending, e); end
      e = sb.pop_front(); vectors++;
      if ({31'h0, irq} !== e) begin miscompares++; $display("FAIL ev_fall_irq got %h want %h", irq, e); end
   endtask

   task automatic test_set_clear_race();
      do_reset();
      rise_enable = 32'h1;
      pad_input = 32'h1;
      sb.push_back(32'h1); sb.push_back(32'h1); sb.push_back(32'h0);
      tick(18);
      e = sb.pop_front(); vectors++;
      if (rise_pulse !== e) begin miscompares++; $display("FAIL race_rise got %h want %h", rise_pulse, e); end
      event_clear = 32'h1;
      tick(1);
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL race_set_wins got %h want %h", event_pending, e); end
      tick(1);
      event_clear = 32'h0;
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL race_later_clear got %h want %h", event_pending, e); end
   endtask

   task automatic test_reset_mid_operation();
      logic [31:0] pulse_seen;
      do_reset();
      rise_enable = 32'h5; irq_enable = 32'h5;
      pad_input = 32'h5;
      sb.push_back(32'h5);
      tick(19);
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL mid_pend5 got %h want %h", event_pending, e); end
      pad_input = 32'h7;
      tick(12);
      reset_n = 1'b0; pad_input = 32'h0;
      sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
      tick(1);
      e = sb.pop_front(); vectors++;
      if (event_pending !== e) begin miscompares++; $display("FAIL mid_rst_pend got %h want %h", event_pending, e); end
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL mid_rst_cond got %h want %h", gpio_input_conditioned, e); end
      e = sb.pop_front(); vectors++;
      if ({31'h0, irq} !== e) begin miscompares++; $display("FAIL mid_rst_irq got %h want %h", irq, e); end
      e = sb.pop_front(); vectors++;
      if ((rise_pulse | fall_pulse) !== e) begin miscompares++; $display("FAIL mid_rst_pulse got %h want %h", rise_pulse | fall_pulse, e); end
      reset_n = 1'b1;
      pulse_seen = 32'h0;
      sb.push_back(32'h0);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         pulse_seen = pulse_seen | rise_pulse | fall_pulse | event_pending;
      end
      e = sb.pop_front(); vectors++;
      if (pulse_seen !== e) begin miscompares++; $display("FAIL mid_release_quiet got %h want %h", pulse_seen, e); end
      pad_input = 32'h2;
      sb.push_back(32'h0); sb.push_back(32'h2);
      tick(17);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL mid_recount_e17 got %h want %h", gpio_input_conditioned, e); end
      tick(1);
      e = sb.pop_front(); vectors++;
      if (gpio_input_conditioned !== e) begin miscompares++; $display("FAIL mid_recount_e18 got %h want %h", gpio_input_conditioned, e); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_debounce();
      test_bypass();
      test_events();
      test_set_clear_race();
      test_reset_mid_operation();
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
